// File: rtl/slave_rx.sv
// slave_rx: valid/ready byte-stream sink with a circular buffer, read port, occupancy FSM and sticky errors.
// Optional: define RX_WORD_CNT_EN to add the rx_cnt accepted-word counter output.
module slave_rx #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic [1:0]       state,
`ifdef RX_WORD_CNT_EN
    output logic [15:0]      rx_cnt,
`endif
    output logic [1:0]       err
);
    localparam int DEPTH_N = 1 << AW;
    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_PARTIAL = 2'd1, S_FULL = 2'd2, S_DRAIN = 2'd3} state_t;

    logic [WIDTH-1:0] mem_q [0:DEPTH_N-1];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             ready_q, empty_q, full_q;
    logic [WIDTH-1:0] data_out_q;
    logic [1:0]       err_q;
    state_t           state_q, state_d;
    logic             prev_valid_q, prev_ready_q;
    logic [WIDTH-1:0] prev_data_q;
    logic             accept, pop, underflow, proto_err;

    // Handshake decode; ready comes from a register so valid/rd_en never reach it combinationally
    always_comb begin
        accept    = valid && ready_q;
        pop       = rd_en && !empty_q;
        underflow = rd_en && empty_q;
        proto_err = prev_valid_q && !prev_ready_q && (!valid || data_in != prev_data_q);
        count_d   = count_q + (AW+1)'(accept) - (AW+1)'(pop);
    end

    // Occupancy FSM next state; S_DRAIN marks the cycle right after space reopens from full
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY:   state_d = accept ? S_PARTIAL : S_EMPTY;
            S_PARTIAL: state_d = (count_d == DEPTH) ? S_FULL : (count_d == '0) ? S_EMPTY : S_PARTIAL;
            S_FULL:    state_d = pop ? S_DRAIN : S_FULL;
            S_DRAIN:   state_d = (count_d == '0) ? S_EMPTY : (count_d == DEPTH) ? S_FULL : S_PARTIAL;
            default:   state_d = S_EMPTY;
        endcase
    end

    // Buffer storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= data_in;
    end

    // Pointers, occupancy, read data, ready and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            state_q    <= S_EMPTY;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                data_out_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            ready_q <= count_d < DEPTH;
            empty_q <= count_d == '0;
            full_q  <= count_d == DEPTH;
            state_q <= state_d;
        end
    end

    // Protocol history and sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_valid_q <= 1'b0;
            prev_ready_q <= 1'b0;
            prev_data_q  <= '0;
            err_q        <= '0;
        end else begin
            prev_valid_q <= valid;
            prev_ready_q <= ready_q;
            prev_data_q  <= data_in;
            err_q        <= err_q | {proto_err, underflow};
        end
    end

`ifdef RX_WORD_CNT_EN
    logic [15:0] rx_cnt_q;

    // Accepted-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) rx_cnt_q <= '0;
        else if (accept) rx_cnt_q <= rx_cnt_q + 16'd1;
    end

    assign rx_cnt = rx_cnt_q;
`endif

    assign ready    = ready_q;
    assign data_out = data_out_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign state    = state_q;
    assign err      = err_q;
endmodule

// File: tb/tb_slave_rx.sv
// tb_slave_rx: directed self-checking bench for slave_rx.
module tb_slave_rx;
    logic       clk = 1'b0;
    logic       rst_n, valid, rd_en;
    logic [7:0] data_in, data_out;
    logic       ready, empty, full;
    logic [4:0] count;
    logic [1:0] state, err;
    int         n_cmp = 0;
    int         n_bad = 0;
`ifdef RX_WORD_CNT_EN
    logic [15:0] rx_cnt;
`endif

    slave_rx #(.WIDTH(8), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data_in(data_in), .ready(ready),
        .rd_en(rd_en), .data_out(data_out), .empty(empty), .full(full), .count(count),
        .state(state),
`ifdef RX_WORD_CNT_EN
        .rx_cnt(rx_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            data_in = base + 8'(i);
            step();
        end
        valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        step();
        step();
        check("rst_ready", ready, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_state", state, 0);
        check("rst_err", err, 0);
        check("rst_dout", data_out, 0);
        rst_n = 1'b1;
        #1;
        check("ready_hold_low", ready, 0);
        step();
        check("ready_up", ready, 1);

        valid = 1'b1; data_in = 8'hA5;
        step();
        check("single_count1", count, 1);
        check("single_state", state, 1);
        valid = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("single_dout", data_out, 8'hA5);
        check("single_count0", count, 0);
        check("single_empty", empty, 1);

        push_n(16, 8'h00);
        check("fill_full", full, 1);
        check("fill_ready", ready, 0);
        check("fill_state", state, 2);
        check("fill_count", count, 16);
        valid = 1'b1; data_in = 8'h10;
        step();
        check("held_count", count, 16);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("pop_dout", data_out, 8'h00);
        check("drain_state", state, 3);
        check("drain_ready", ready, 1);
        check("drain_count", count, 15);
        step();
        valid = 1'b0;
        check("late_count", count, 16);
        check("late_ready", ready, 0);
        check("fill_err", err, 0);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("drain_%0d", i), data_out, 8'(i + 1));
        end
        rd_en = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_state0", state, 0);

        push_n(10, 8'h50);
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rd_en = 1'b0;
        check("wrap_mid_dout", data_out, 8'h59);
        push_n(12, 8'h20);
        check("wrap_count12", count, 12);
        rd_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("wrap_%0d", i), data_out, 8'h20 + 8'(i));
        end
        rd_en = 1'b0;
        check("wrap_count0", count, 0);

        push_n(5, 8'h60);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            data_in = 8'h65 + 8'(i);
            step();
            check($sformatf("sim_dout_%0d", i), data_out, 8'h60 + 8'(i));
            check($sformatf("sim_count_%0d", i), count, 5);
        end
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sim_tail_%0d", i), data_out, 8'h68 + 8'(i));
        end
        check("sim_empty", empty, 1);
        check("no_err_yet", err, 0);
        step();
        rd_en = 1'b0;
        check("uflow_err", err, 1);
        check("uflow_dout", data_out, 8'h6C);
        valid = 1'b1; rd_en = 1'b1; data_in = 8'h77;
        step();
        valid = 1'b0; rd_en = 1'b0;
        check("empty_rw_count", count, 1);
        check("empty_rw_dout", data_out, 8'h6C);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("empty_rw_late", data_out, 8'h77);
        check("empty_rw_count0", count, 0);

        push_n(16, 8'h80);
        valid = 1'b1; data_in = 8'h3C;
        step();
        check("proto_quiet", err, 1);
        data_in = 8'h3D;
        step();
        check("proto_err", err, 3);
        valid = 1'b0;
        step();
        check("proto_sticky", err, 3);
        check("proto_count", count, 16);
`ifdef RX_WORD_CNT_EN
        check("rx_cnt", rx_cnt, 70);
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rerst_err", err, 0);
        check("rerst_count", count, 0);
        check("rerst_empty", empty, 1);
        check("rerst_ready", ready, 0);
`ifdef RX_WORD_CNT_EN
        check("rerst_rx_cnt", rx_cnt, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
